// File: rtl/seq_mag_cmp_if.sv
// Request/response bundle for the serial magnitude comparator.
// The master drives operands and start. The slave returns busy, done and the one-hot result.
interface seq_mag_cmp_if #(parameter int WIDTH = 16);
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [2:0]       o;

  modport master (output start, signed_mode, a, b, input busy, done, o);
  modport slave  (input start, signed_mode, a, b, output busy, done, o);
endinterface

// File: rtl/seq_mag_cmp.sv
// Serial magnitude comparator: one SLICE-bit stage walks the operands MSB slice first.
// It decides early on the first differing slice.
module seq_mag_cmp #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input logic          clk,
  input logic          rst,
  seq_mag_cmp_if.slave bus
);
  localparam int NSLICE = (SLICE > 0) ? WIDTH / SLICE : 1;
  localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IW-1:0] TOP = IW'(NSLICE - 1);

  generate
    if (SLICE < 1 || WIDTH < 1 || (WIDTH % SLICE) != 0) begin : g_bad_cfg
      $error("seq_mag_cmp: WIDTH must be a positive multiple of SLICE");
    end
  endgenerate

  typedef enum logic {IDLE, CMP} state_t;

  state_t           state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_q, b_q;
  logic             sm_q;
  logic             busy_q, done_q;
  logic [2:0]       o_q;
  logic [SLICE-1:0] sa, sb;

  // Flipping the sign bit of the top slice turns a two's-complement order into an unsigned order.
  always_comb begin
    sa = a_q[int'(idx)*SLICE +: SLICE];
    sb = b_q[int'(idx)*SLICE +: SLICE];
    if (sm_q && idx == TOP) begin
      sa[SLICE-1] = ~sa[SLICE-1];
      sb[SLICE-1] = ~sb[SLICE-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      sm_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      o_q    <= 3'b000;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_q    <= bus.a;
            b_q    <= bus.b;
            sm_q   <= bus.signed_mode;
            idx    <= TOP;
            busy_q <= 1'b1;
            o_q    <= 3'b000;
            state  <= CMP;
          end
        end
        CMP: begin
          if (sa != sb) begin
            o_q    <= (sa > sb) ? 3'b100 : 3'b001;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else if (idx == '0) begin
            o_q    <= 3'b010;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.o    = o_q;
endmodule

// File: doc/seq_mag_cmp.md
SEQ_MAG_CMP -- requirements
Module: seq_mag_cmp

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits.
REQ-002 SHALL have parameter SLICE, default 4, bits compared per clock (one 4-bit comparator stage reused serially).
REQ-003 SHALL reject at elaboration any WIDTH that is not a positive multiple of SLICE; NSLICE = WIDTH/SLICE.
REQ-004 SHALL have port clk  input  1  sole clock, rising-edge active.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port start  input  1  request a comparison; sampled only when idle.
REQ-007 SHALL have port signed_mode  input  1  1 = two's-complement compare, 0 = unsigned.
REQ-008 SHALL have port a  input  WIDTH  operand A.
REQ-009 SHALL have port b  input  WIDTH  operand B.
REQ-010 SHALL have port busy  output  1  comparison in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-012 SHALL have port o  output  3  result, one-hot: o[2] A>B, o[1] A==B, o[0] A<B.

Function
REQ-013 SHALL implement states IDLE and CMP plus a slice index idx of ceil(log2(NSLICE)) bits (minimum 1).
REQ-014 SHALL, in IDLE with start=1 at a rising edge, capture a, b, signed_mode into internal registers, set idx=NSLICE-1, enter CMP, set busy=1, clear o to 3'b000.
REQ-015 SHALL ignore start while in CMP; changes on a, b, signed_mode after capture SHALL NOT affect the result.
REQ-016 SHALL, in CMP at each rising edge, compare captured slice [idx*SLICE+SLICE-1 : idx*SLICE] of A against B, MSB slice first.
REQ-017 SHALL, in signed mode only, invert the MSB of both operands in the top slice before comparing, so negative < positive.
REQ-018 SHALL, when the current slices differ, decide immediately (early exit): o = 3'b100 if A slice > B slice else 3'b001.
REQ-019 SHALL, when slices are equal and idx=0, decide o = 3'b010; when equal and idx>0, decrement idx and stay in CMP.
REQ-020 SHALL, at the deciding edge, register o, pulse done=1 for exactly one cycle, clear busy, return to IDLE.
REQ-021 SHALL give latency j cycles from the capture edge to done high, j = number of slices examined, 1 <= j <= NSLICE.
REQ-022 SHALL hold o at the last result while IDLE until the next accepted start.
REQ-023 SHALL accept start in the same cycle done is high (back-to-back); that start clears o at its capture edge.
REQ-024 SHALL never assert busy and done in the same cycle; o SHALL always be one-hot or 3'b000.

Reset
REQ-025 SHALL on rst=1, asynchronously and independent of clk: state=IDLE, idx=0, busy=0, done=0, o=3'b000, captured registers=0.
REQ-026 SHALL abort an in-progress comparison on reset with no done pulse; first start after rst deasserts behaves as from power-up.

Verification
REQ-027 Unsigned, a=16'h9000, b=16'h8FFF, start -> done 1 cycle after capture, o=3'b100, busy high 1 cycle.
REQ-028 Unsigned, a=b=16'h1234 -> done 4 cycles after capture, o=3'b010; a=16'h1239, b=16'h123B -> done after 4, o=3'b001.
REQ-029 Signed, a=16'hFFFF (-1), b=16'h0001 -> o=3'b001 after 1 cycle; same operands unsigned -> o=3'b100.
REQ-030 start asserted each cycle, a/b changed while busy -> only captured operands determine o; extra starts ignored; back-to-back start on done cycle accepted.
REQ-031 rst pulsed mid-comparison (idx=2) asynchronously between edges -> busy, done, o drop to 0 immediately, no done pulse follows.
REQ-032 Exhaustive sweep with WIDTH=8, SLICE=4, both modes, all 65536 operand pairs -> o matches reference compare, latency 1 or 2.
